// File: rtl/axi4_lite_defs.sv
// Shared definitions for the AXI4-Lite register-file port: response codes,
// register-file geometry and the write/read FSM state encodings.
package axi4_lite_defs;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int RF_AW = 4;
  localparam int DW    = 32;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_ISSUE = 2'd1,
    W_RESP  = 2'd2
  } wstate_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rstate_e;

endpackage

// File: rtl/axi4_lite_rf_port.sv
// AXI4-Lite slave that turns each write/read transaction into a single-cycle
// register-file request. Write and read channels are independent FSMs.
module axi4_lite_rf_port
  import axi4_lite_defs::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk0,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DW-1:0]         s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DW-1:0]         s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  wr_en,
  output logic [RF_AW-1:0]      wr_addr,
  output logic [DW-1:0]         wr_data,
  output logic                  rd_en,
  output logic [RF_AW-1:0]      rd_addr,
  input  logic [DW-1:0]         rd_data
);

  localparam logic [1:0] LAT = 2'(RD_LATENCY);

  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> 6) != '0;
  endfunction

  // Byte-offset bits never reach the register file.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // ---------------- write channel ----------------
  wstate_e          w_q, w_d;
  logic             aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [RF_AW-1:0] aw_idx_q, aw_idx_d;
  logic             aw_oor_q, aw_oor_d;
  logic [DW-1:0]    wdat_q, wdat_d;
  logic             wfull_q, wfull_d;
  logic             awready_q, awready_d, wready_q, wready_d;
  logic             bvalid_q, bvalid_d;
  logic [1:0]       bresp_q, bresp_d;
  logic             wr_en_q, wr_en_d;
  logic [RF_AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0]    wr_data_q, wr_data_d;
  logic             w_ok;

  always_comb begin
    w_d       = w_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    aw_idx_d  = aw_idx_q;
    aw_oor_d  = aw_oor_q;
    wdat_d    = wdat_q;
    wfull_d   = wfull_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    w_ok      = 1'b0;
    case (w_q)
      W_IDLE: begin
        if (s_axi_awvalid && awready_q) begin
          aw_got_d = 1'b1;
          aw_idx_d = s_axi_awaddr[5:2];
          aw_oor_d = out_of_range(s_axi_awaddr);
        end
        if (s_axi_wvalid && wready_q) begin
          w_got_d = 1'b1;
          wdat_d  = s_axi_wdata;
          wfull_d = (s_axi_wstrb == 4'hF);
        end
        if (aw_got_d && w_got_d) begin
          w_ok     = !aw_oor_d && wfull_d;
          w_d      = W_ISSUE;
          aw_got_d = 1'b0;
          w_got_d  = 1'b0;
          wr_en_d  = w_ok;
          bresp_d  = w_ok ? RESP_OKAY : RESP_SLVERR;
          if (w_ok) begin
            wr_addr_d = aw_idx_d;
            wr_data_d = wdat_d;
          end
        end
      end
      W_ISSUE: begin
        w_d      = W_RESP;
        bvalid_d = 1'b1;
      end
      W_RESP: begin
        if (s_axi_bready) begin
          w_d      = W_IDLE;
          bvalid_d = 1'b0;
        end
      end
      default: w_d = W_IDLE;
    endcase
    // Ready is registered so it reads 0 while reset is held.
    awready_d = (w_d == W_IDLE) && !aw_got_d;
    wready_d  = (w_d == W_IDLE) && !w_got_d;
  end

  always_ff @(posedge clk0) begin
    if (reset) begin
      w_q       <= W_IDLE;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      aw_idx_q  <= '0;
      aw_oor_q  <= 1'b0;
      wdat_q    <= '0;
      wfull_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      w_q       <= w_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      aw_idx_q  <= aw_idx_d;
      aw_oor_q  <= aw_oor_d;
      wdat_q    <= wdat_d;
      wfull_q   <= wfull_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // ---------------- read channel ----------------
  rstate_e          r_q, r_d;
  logic             arready_q, arready_d;
  logic             rvalid_q, rvalid_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [1:0]       rresp_q, rresp_d;
  logic             rd_en_q, rd_en_d;
  logic [RF_AW-1:0] rd_addr_q, rd_addr_d;
  logic             rerr_q, rerr_d;
  logic [1:0]       cnt_q, cnt_d;

  always_comb begin
    r_d       = r_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    rerr_d    = rerr_q;
    cnt_d     = cnt_q;
    case (r_q)
      R_IDLE: begin
        if (s_axi_arvalid && arready_q) begin
          r_d    = R_WAIT;
          rerr_d = out_of_range(s_axi_araddr);
          cnt_d  = LAT;
          if (!out_of_range(s_axi_araddr)) begin
            rd_en_d   = 1'b1;
            rd_addr_d = s_axi_araddr[5:2];
          end
        end
      end
      R_WAIT: begin
        // cnt starts at RD_LATENCY in the rd_en cycle, so zero lands on valid rd_data.
        if (cnt_q == 2'd0) begin
          r_d      = R_RESP;
          rvalid_d = 1'b1;
          rdata_d  = rerr_q ? '0 : rd_data;
          rresp_d  = rerr_q ? RESP_SLVERR : RESP_OKAY;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      R_RESP: begin
        if (s_axi_rready) begin
          r_d      = R_IDLE;
          rvalid_d = 1'b0;
        end
      end
      default: r_d = R_IDLE;
    endcase
    arready_d = (r_d == R_IDLE);
  end

  always_ff @(posedge clk0) begin
    if (reset) begin
      r_q       <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rerr_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      r_q       <= r_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      rerr_q    <= rerr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign rd_en         = rd_en_q;
  assign rd_addr       = rd_addr_q;

endmodule
